// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the CPU/host memory arbiter.
//   DEFAULT_AW / DEFAULT_DW : default RAM address and data widths
//   owner_t                 : last grant owner (IDLE=0, CPU=1, HOST=2)
//   rd_owner_t              : owner of an in-flight read (NONE=0, CPU=1, HOST=2)
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEFAULT_AW = 8;
    localparam int DEFAULT_DW = 8;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_HOST = 2'd2
    } rd_owner_t;

endpackage

// File: rtl/mem_arb_rdret.sv
// ----------------------------------------------------------------------------
// mem_arb_rdret
// Tracks which port issued the read on the previous edge and steers the
// registered RAM output back to that port only.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   cpu_rd, host_rd          : read issued to the RAM this cycle (one-hot or 0)
//   ram_q                    : RAM registered read data
//   cpu_rvalid, cpu_rdata    : CPU read return (rdata is 0 when not valid)
//   host_rvalid, host_rdata  : host read return (rdata is 0 when not valid)
// ----------------------------------------------------------------------------
module mem_arb_rdret
    import mem_arb_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd,
    input  logic          host_rd,
    input  logic [DW-1:0] ram_q,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata
);

    rd_owner_t rd_owner;
    rd_owner_t rd_owner_next;

    // The owner of the read issued this cycle; at most one of the inputs is set.
    always_comb begin
        rd_owner_next = RD_NONE;
        if (cpu_rd) begin
            rd_owner_next = RD_CPU;
        end else if (host_rd) begin
            rd_owner_next = RD_HOST;
        end
    end

    // Reset clears the owner, so a read issued just before reset never returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= RD_NONE;
        end else begin
            rd_owner <= rd_owner_next;
        end
    end

    // Return demux: only the owning port sees the data, the other sees zero.
    always_comb begin
        cpu_rvalid  = 1'b0;
        host_rvalid = 1'b0;
        cpu_rdata   = '0;
        host_rdata  = '0;
        if (rd_owner == RD_CPU) begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = ram_q;
        end else if (rd_owner == RD_HOST) begin
            host_rvalid = 1'b1;
            host_rdata  = ram_q;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port RAM between a CPU port and a host (program loader)
// port. Grants are combinational and the access is issued in the same cycle;
// read data comes back one cycle later on the port that issued the read.
//
// Configuration macro MEM_ARB_RR_EN:
//   undefined : fixed priority, the CPU always wins contention.
//   defined   : round-robin; a host holding the grant under contention keeps
//               it for MAX_BURST consecutive grants, then yields one cycle.
//
// Ports:
//   clk, rst                                  : clock, async active-high reset
//   cpu_req/we/addr/wdata                     : CPU request
//   cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall : CPU grant, read return, halt
//   host_req/we/addr/wdata                    : host request
//   host_gnt, host_rvalid, host_rdata         : host grant, read return
//   ram_addr, ram_data, ram_rden, ram_wren    : RAM command (all 0 when idle)
//   ram_q                                     : RAM registered read data
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = DEFAULT_AW,
    parameter int DW        = DEFAULT_DW,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_rden,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    localparam int             BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);

    owner_t        last_owner;
    owner_t        last_owner_next;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_cnt_next;
    logic          cpu_win;
    logic          host_win;

    // Arbitration. Without contention the lone requester always wins; under
    // contention the winner depends on the build mode.
    always_comb begin
        cpu_win  = 1'b0;
        host_win = 1'b0;
        if (cpu_req && host_req) begin
`ifdef MEM_ARB_RR_EN
            case (last_owner)
                OWN_CPU:  host_win = 1'b1;
                OWN_HOST: begin
                    if (burst_cnt < BURST_MAX) begin
                        host_win = 1'b1;
                    end else begin
                        cpu_win = 1'b1;
                    end
                end
                default:  cpu_win = 1'b1;
            endcase
`else
            cpu_win = 1'b1;
`endif
        end else begin
            cpu_win  = cpu_req;
            host_win = host_req;
        end
    end

    // Nothing is granted while reset is held, even if requests are present.
    assign cpu_gnt   = cpu_win & ~rst;
    assign host_gnt  = host_win & ~rst;
    assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

    // RAM command mux; an idle cycle drives all zeros.
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_rden = 1'b0;
        ram_wren = 1'b0;
        if (cpu_gnt) begin
            ram_addr = cpu_addr;
            ram_data = cpu_wdata;
            ram_rden = ~cpu_we;
            ram_wren = cpu_we;
        end else if (host_gnt) begin
            ram_addr = host_addr;
            ram_data = host_wdata;
            ram_rden = ~host_we;
            ram_wren = host_we;
        end
    end

    // Next arbitration state. burst_cnt counts consecutive host grants made
    // while the CPU was also asking; any other cycle starts the count over.
    always_comb begin
        last_owner_next = OWN_IDLE;
        burst_cnt_next  = '0;
        if (cpu_win) begin
            last_owner_next = OWN_CPU;
        end else if (host_win) begin
            last_owner_next = OWN_HOST;
        end
        if (host_win && cpu_req) begin
            if (last_owner != OWN_HOST) begin
                burst_cnt_next = BW'(1);
            end else if (burst_cnt >= BURST_MAX) begin
                burst_cnt_next = BURST_MAX;
            end else begin
                burst_cnt_next = burst_cnt + BW'(1);
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWN_IDLE;
            burst_cnt  <= '0;
        end else begin
            last_owner <= last_owner_next;
            burst_cnt  <= burst_cnt_next;
        end
    end

    mem_arb_rdret #(
        .DW (DW)
    ) u_rdret (
        .clk         (clk),
        .rst         (rst),
        .cpu_rd      (cpu_gnt & ~cpu_we),
        .host_rd     (host_gnt & ~host_we),
        .ram_q       (ram_q),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A RAM model answers the DUT's RAM port;
// a separate rule-based reference (shadow memory, last winner, host streak,
// pending read) predicts every output each cycle. Directed sequences pin the
// reference with literal values. Honours MEM_ARB_RR_EN like the DUT.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, host_req, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic          cpu_gnt, cpu_rvalid, cpu_stall, host_gnt, host_rvalid;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
    logic          ram_rden, ram_wren;

    int checks = 0;
    int errors = 0;

    // RAM environment and reference shadow memory
    logic [DW-1:0] ram    [256];
    logic [DW-1:0] shadow [256];

    // Reference state: 0 = nobody, 1 = CPU, 2 = host
    int            prev_winner = 0;
    int            streak      = 0;
    int            pend_owner  = 0;
    logic [DW-1:0] pend_data   = '0;
    logic          mdl_cpu_gnt = 1'b0;
    logic          mdl_host_gnt = 1'b0;

    mem_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_rden    (ram_rden),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered output.
    always @(posedge clk) begin
        if (ram_wren) ram[ram_addr] <= ram_data;
        if (ram_rden) ram_q <= ram[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                                 input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    task automatic sampleWait();
        @(negedge clk);
        #1;
    endtask

    // Reference compare: predict every output from the arbitration rules,
    // compare, then advance the reference to the next cycle.
    always @(negedge clk) begin : cmp_proc
        logic          cw, hw;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_rden, e_wren, e_crv, e_hrv;
        cw = 1'b0;
        hw = 1'b0;
        if (rst) begin
            cw = 1'b0;
            hw = 1'b0;
        end else if (cpu_req && host_req) begin
`ifdef MEM_ARB_RR_EN
            if (prev_winner == 2 && streak < MAX_BURST) hw = 1'b1;
            else if (prev_winner == 1) hw = 1'b1;
            else cw = 1'b1;
`else
            cw = 1'b1;
`endif
        end else begin
            cw = cpu_req;
            hw = host_req;
        end
        e_addr = cw ? cpu_addr : (hw ? host_addr : '0);
        e_data = cw ? cpu_wdata : (hw ? host_wdata : '0);
        e_rden = (cw && !cpu_we) || (hw && !host_we);
        e_wren = (cw && cpu_we) || (hw && host_we);
        e_crv  = !rst && pend_owner == 1;
        e_hrv  = !rst && pend_owner == 2;

        checkOutput("cpu_gnt", cpu_gnt, cw);
        checkOutput("host_gnt", host_gnt, hw);
        checkOutput("cpu_stall", cpu_stall, !rst && cpu_req && !cw);
        checkOutput("ram_addr", ram_addr, e_addr);
        checkOutput("ram_data", ram_data, e_data);
        checkOutput("ram_rden", ram_rden, e_rden);
        checkOutput("ram_wren", ram_wren, e_wren);
        checkOutput("cpu_rvalid", cpu_rvalid, e_crv);
        checkOutput("cpu_rdata", cpu_rdata, e_crv ? pend_data : '0);
        checkOutput("host_rvalid", host_rvalid, e_hrv);
        checkOutput("host_rdata", host_rdata, e_hrv ? pend_data : '0);

        mdl_cpu_gnt  = cw;
        mdl_host_gnt = hw;

        if (rst) begin
            prev_winner = 0;
            streak      = 0;
            pend_owner  = 0;
        end else begin
            pend_owner = (cw && !cpu_we) ? 1 : ((hw && !host_we) ? 2 : 0);
            pend_data  = cw ? shadow[cpu_addr] : shadow[host_addr];
            if (cw && cpu_we) shadow[cpu_addr] = cpu_wdata;
            if (hw && host_we) shadow[host_addr] = host_wdata;
            if (hw && cpu_req) streak = (streak < MAX_BURST) ? streak + 1 : MAX_BURST;
            else streak = 0;
            prev_winner = cw ? 1 : (hw ? 2 : 0);
        end
    end

    initial begin
        logic [10:0] rr_cpu_pattern;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        ram[8'h10] = 8'h5A; shadow[8'h10] = 8'h5A;
        ram[8'h01] = 8'h11; shadow[8'h01] = 8'h11;
        ram[8'h02] = 8'h22; shadow[8'h02] = 8'h22;
        ram_q = '0;

        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // CPU read of 0x10 returns the preloaded 0x5A one cycle later
        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        sampleWait();
        checkOutput("lit_cpu_gnt_c0", cpu_gnt, 1);
        checkOutput("lit_ram_rden_c0", ram_rden, 1);
        checkOutput("lit_ram_addr_c0", ram_addr, 8'h10);
        checkOutput("lit_host_gnt_c0", host_gnt, 0);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        sampleWait();
        checkOutput("lit_cpu_rvalid_c1", cpu_rvalid, 1);
        checkOutput("lit_cpu_rdata_c1", cpu_rdata, 8'h5A);
        checkOutput("lit_host_rvalid_c1", host_rvalid, 0);

        // Host writes 0xA5 to 0x20, CPU reads it back
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hA5);
        sampleWait();
        checkOutput("lit_wr_wren", ram_wren, 1);
        checkOutput("lit_wr_data", ram_data, 8'hA5);
        checkOutput("lit_wr_addr", ram_addr, 8'h20);
        applyStimulus(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
        sampleWait();
        checkOutput("lit_wr_no_rvalid", host_rvalid, 0);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        sampleWait();
        checkOutput("lit_rb_rdata", cpu_rdata, 8'hA5);

`ifdef MEM_ARB_RR_EN
        // Contention from idle: CPU first, then 4 host grants, 1 CPU, repeating
        rr_cpu_pattern = 11'b10000100001;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00);
            sampleWait();
            checkOutput($sformatf("lit_rr_cpu_gnt_%0d", i), cpu_gnt, rr_cpu_pattern[i]);
            checkOutput($sformatf("lit_rr_host_gnt_%0d", i), host_gnt, !rr_cpu_pattern[i]);
            checkOutput($sformatf("lit_rr_stall_%0d", i), cpu_stall, !rr_cpu_pattern[i]);
        end
`else
        // Fixed priority: the CPU holds the RAM for 6 cycles, host waits
        rr_cpu_pattern = '0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00);
            sampleWait();
            checkOutput($sformatf("lit_fp_cpu_gnt_%0d", i), cpu_gnt, 1);
            checkOutput($sformatf("lit_fp_host_gnt_%0d", i), host_gnt, 0);
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h31, 8'h00);
        sampleWait();
        checkOutput("lit_fp_host_after", host_gnt, 1);
`endif
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        // Alternating reads: each return reaches only its own port
        applyStimulus(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00);
        sampleWait();
        checkOutput("lit_alt_cpu_rdata", cpu_rdata, 8'h11);
        checkOutput("lit_alt_host_rvalid0", host_rvalid, 0);
        applyStimulus(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
        sampleWait();
        checkOutput("lit_alt_host_rdata", host_rdata, 8'h22);
        checkOutput("lit_alt_cpu_rvalid0", cpu_rvalid, 0);

        // Reset right after a CPU read grant: the return is dropped
        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        host_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sampleWait();
            checkOutput("lit_rst_cpu_rvalid", cpu_rvalid, 0);
            checkOutput("lit_rst_cpu_gnt", cpu_gnt, 0);
            checkOutput("lit_rst_stall", cpu_stall, 0);
            checkOutput("lit_rst_ram_rden", ram_rden, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h02; host_req = 0;
        sampleWait();
        checkOutput("lit_post_rst_gnt", cpu_gnt, 1);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        sampleWait();
        checkOutput("lit_post_rst_rdata", cpu_rdata, 8'h22);

        // Randomised traffic; requesters hold their request until granted
        for (int i = 0; i < 1500; i++) begin
            logic          cr, cw2, hr, hw2;
            logic [AW-1:0] ca, ha;
            logic [DW-1:0] cd, hd;
            cr = cpu_req; cw2 = cpu_we; ca = cpu_addr; cd = cpu_wdata;
            hr = host_req; hw2 = host_we; ha = host_addr; hd = host_wdata;
            if (!cpu_req || mdl_cpu_gnt) begin
                cr  = ($urandom_range(0, 3) != 0);
                cw2 = $urandom_range(0, 1) == 1;
                ca  = 8'(8'h30 + $urandom_range(0, 15));
                cd  = 8'($urandom);
            end
            if (!host_req || mdl_host_gnt) begin
                hr  = ($urandom_range(0, 3) != 0);
                hw2 = $urandom_range(0, 1) == 1;
                ha  = 8'(8'h30 + $urandom_range(0, 15));
                hd  = 8'($urandom);
            end
            applyStimulus(cr, cw2, ca, cd, hr, hw2, ha, hd);
            rst = ($urandom_range(0, 199) == 0);
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
